// File: rtl/cnn_fifo_pkg.sv
// Shared constants for the conv-path channel FIFO read scheduler.
package cnn_fifo_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BURST = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   // Channel-index width, never zero so a degenerate build still elaborates.
   function automatic int ch_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fifo_rr_read_arb_rr_pick.sv
// Combinational round-robin picker: first requester after `last`, wrapping.
module rr_pick
   import cnn_fifo_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CH_W   = ch_idx_w(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   last,
   output logic              found,
   output logic [CH_W-1:0]   idx
);

   logic [CH_W-1:0] cand;

   always_comb begin
      // NOTE: every output of this block gets a default before the scan, so no path infers a latch.
      found = 1'b0;
      idx   = '0;
      cand  = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         cand = CH_W'((int'(last) + i) % NUM_CH);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/fifo_rr_read_arb.sv
// Bursting round-robin drain of NUM_CH registered-read FIFOs into one tagged valid/ready stream.
module fifo_rr_read_arb
   import cnn_fifo_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int DATA_W     = 64,
   parameter int BURST_LEN  = 16,
   parameter int OBUF_DEPTH = 4,
   parameter int CH_W       = $clog2(NUM_CH),
   parameter int BL_W       = $clog2(BURST_LEN + 1)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     enable,
   input  logic [NUM_CH-1:0]        fifo_empty,
   output logic [NUM_CH-1:0]        fifo_rd_en,
   input  logic [NUM_CH*DATA_W-1:0] fifo_rd_data,
   input  logic [NUM_CH-1:0]        fifo_valid,
   output logic [DATA_W-1:0]        m_data,
   output logic [CH_W-1:0]          m_ch,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic                     busy,
   output logic                     grant_done,
   output logic [BL_W-1:0]          grant_beats
);

   localparam int PW = $clog2(OBUF_DEPTH);

   logic [1:0]        state;
   logic [CH_W-1:0]   grant;
   logic [CH_W-1:0]   last_grant;
   logic [BL_W-1:0]   beat_cnt;
   logic              pending;

   logic [PW:0]       occ;
   logic [PW-1:0]     wr_ptr;
   logic [PW-1:0]     rd_ptr;
   logic [DATA_W-1:0] obuf_data [OBUF_DEPTH];
   logic [CH_W-1:0]   obuf_ch   [OBUF_DEPTH];

   logic              pick_found;
   logic [CH_W-1:0]   pick_idx;
   logic [PW+1:0]     fill;
   logic              room;
   logic              rd_issue;
   logic              burst_end;
   logic              capture;
   logic              pop;

   rr_pick #(
      .NUM_CH (NUM_CH),
      .CH_W   (CH_W)
   ) u_pick (
      .req   (~fifo_empty),
      .last  (last_grant),
      .found (pick_found),
      .idx   (pick_idx)
   );

   // An in-flight read already owns a buffer slot, so room counts it too.
   assign fill      = {1'b0, occ} + {{(PW + 1){1'b0}}, pending};
   assign room      = fill < (PW + 2)'(OBUF_DEPTH);
   assign rd_issue  = (state == BURST) && enable && !fifo_empty[grant]
                      && (beat_cnt < BL_W'(BURST_LEN)) && room;
   assign burst_end = (beat_cnt == BL_W'(BURST_LEN)) || fifo_empty[grant] || !enable;
   assign capture   = pending && fifo_valid[grant];
   assign pop       = m_valid && m_ready;

   assign fifo_rd_en  = rd_issue ? (NUM_CH'(1) << grant) : '0;
   assign m_valid     = (occ != '0);
   assign m_data      = m_valid ? obuf_data[rd_ptr] : '0;
   assign m_ch        = m_valid ? obuf_ch[rd_ptr] : '0;
   assign busy        = (state != IDLE);
   assign grant_done  = (state == DRAIN) && !pending;
   assign grant_beats = grant_done ? beat_cnt : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         last_grant <= CH_W'(NUM_CH - 1);
         beat_cnt   <= '0;
         pending    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         case (state)
            IDLE: begin
               if (enable && pick_found) begin
                  grant    <= pick_idx;
                  beat_cnt <= '0;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (rd_issue) begin
                  beat_cnt <= beat_cnt + BL_W'(1);
               end else if (burst_end) begin
                  state      <= DRAIN;
                  last_grant <= grant;
               end
            end
            DRAIN: begin
               if (!pending) state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (rd_issue)     pending <= 1'b1;
         else if (capture) pending <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (capture) wr_ptr <= wr_ptr + PW'(1);
         if (pop)     rd_ptr <= rd_ptr + PW'(1);
         case ({capture, pop})
            2'b10:   occ <= occ + (PW + 1)'(1);
            2'b01:   occ <= occ - (PW + 1)'(1);
            default: ;
         endcase
      end
   end

   // NOTE: buffer storage is not reset; occ and the m_valid gating keep stale entries invisible.
   always_ff @(posedge clk) begin
      if (capture) begin
         obuf_data[wr_ptr] <= fifo_rd_data[grant*DATA_W +: DATA_W];
         obuf_ch[wr_ptr]   <= grant;
      end
   end

endmodule

// File: tb/tb_fifo_rr_read_arb.sv
// Directed bench: behavioural registered-read FIFOs per channel plus a beat/grant scoreboard.
module tb_fifo_rr_read_arb;

   localparam int NUM_CH     = 4;
   localparam int DATA_W     = 64;
   localparam int BURST_LEN  = 16;
   localparam int OBUF_DEPTH = 4;
   localparam int CH_W       = 2;
   localparam int BL_W       = 5;
   localparam int BW         = CH_W + DATA_W;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     enable;
   logic [NUM_CH-1:0]        fifo_empty;
   logic [NUM_CH-1:0]        fifo_rd_en;
   logic [NUM_CH*DATA_W-1:0] fifo_rd_data;
   logic [NUM_CH-1:0]        fifo_valid;
   logic [DATA_W-1:0]        m_data;
   logic [CH_W-1:0]          m_ch;
   logic                     m_valid;
   logic                     m_ready;
   logic                     busy;
   logic                     grant_done;
   logic [BL_W-1:0]          grant_beats;

   int checks   = 0;
   int failures = 0;

   int avail [NUM_CH];
   int nseq  [NUM_CH];
   int cyc = 0;
   int rd_total, rx_total, max_out;
   int onehot_err = 0;
   int rdempty_err = 0;
   int en_cyc;
   bit rdy_mode = 1'b0;

   logic [BW-1:0] rx_q [$];
   logic [BW-1:0] exp_q [$];
   int rx_cyc [$];
   int rd_cyc [$];
   int gd_q [$];
   int gd_cyc [$];
   int exp_gd [$];

   fifo_rr_read_arb #(
      .NUM_CH     (NUM_CH),
      .DATA_W     (DATA_W),
      .BURST_LEN  (BURST_LEN),
      .OBUF_DEPTH (OBUF_DEPTH)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .enable       (enable),
      .fifo_empty   (fifo_empty),
      .fifo_rd_en   (fifo_rd_en),
      .fifo_rd_data (fifo_rd_data),
      .fifo_valid   (fifo_valid),
      .m_data       (m_data),
      .m_ch         (m_ch),
      .m_valid      (m_valid),
      .m_ready      (m_ready),
      .busy         (busy),
      .grant_done   (grant_done),
      .grant_beats  (grant_beats)
   );

   always #5 clk = ~clk;

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) fifo_empty[k] = (avail[k] == 0);
   end

   function automatic logic [DATA_W-1:0] mk_word(input int k, input int s);
      return {32'(k), 32'(s)};
   endfunction

   function automatic logic [BW-1:0] mk_beat(input int k, input int s);
      return {CH_W'(k), mk_word(k, s)};
   endfunction

   task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes mid-cycle, then advance the FIFO models after the edge.
   task automatic tick();
      logic [NUM_CH-1:0] re;
      @(negedge clk);
      re = fifo_rd_en;
      if (!rst) begin
         if ($countones(re) > 1) onehot_err++;
         for (int k = 0; k < NUM_CH; k++) if (re[k] && avail[k] == 0) rdempty_err++;
         if (re != '0) begin
            rd_total++;
            rd_cyc.push_back(cyc);
         end
         if (m_valid && m_ready) begin
            rx_q.push_back({m_ch, m_data});
            rx_cyc.push_back(cyc);
            rx_total++;
         end
         if (grant_done) begin
            gd_q.push_back(int'(grant_beats));
            gd_cyc.push_back(cyc);
         end
         if (rd_total - rx_total > max_out) max_out = rd_total - rx_total;
      end
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_CH; k++) begin
         fifo_valid[k] = 1'b0;
         if (re[k] === 1'b1 && avail[k] > 0) begin
            fifo_rd_data[k*DATA_W +: DATA_W] = mk_word(k, nseq[k]);
            nseq[k]++;
            avail[k]--;
            fifo_valid[k] = 1'b1;
         end
      end
      cyc++;
      if (rdy_mode) m_ready = (cyc % 3 == 0);
      #1;
   endtask

   task automatic reset_model();
      for (int k = 0; k < NUM_CH; k++) begin
         avail[k] = 0;
         nseq[k]  = 0;
      end
      fifo_valid = '0;
   endtask

   task automatic clear_sb();
      rd_total = 0;
      rx_total = 0;
      max_out  = 0;
      rx_q.delete();
      rx_cyc.delete();
      rd_cyc.delete();
      gd_q.delete();
      gd_cyc.delete();
      exp_q.delete();
      exp_gd.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      reset_model();
      tick();
      tick();
      rst = 1'b0;
      clear_sb();
   endtask

   task automatic wait_gd(input string tag, input int n, input int bound);
      int t = 0;
      while (gd_q.size() < n && t < bound) begin
         tick();
         t++;
      end
      check(tag, gd_q.size() >= n, 1'b1);
   endtask

   // Expected round-robin order when every channel starts with `words` entries.
   task automatic build_rr(input int words);
      int rem [NUM_CH];
      int left;
      int n;
      for (int k = 0; k < NUM_CH; k++) rem[k] = words;
      left = NUM_CH * words;
      while (left > 0) begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (rem[k] > 0) begin
               n = (rem[k] < BURST_LEN) ? rem[k] : BURST_LEN;
               for (int s = 0; s < n; s++) exp_q.push_back(mk_beat(k, words - rem[k] + s));
               exp_gd.push_back(n);
               rem[k] -= n;
               left   -= n;
            end
         end
      end
   endtask

   task automatic push_exp(input int k, input int n);
      for (int s = 0; s < n; s++) exp_q.push_back(mk_beat(k, s));
      exp_gd.push_back(n);
   endtask

   task automatic compare_stream(input string tag);
      int bad = 0;
      check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
      for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
      check({tag, "_rx_order"}, bad, 0);
      bad = 0;
      check({tag, "_gd_count"}, gd_q.size(), exp_gd.size());
      for (int i = 0; i < gd_q.size() && i < exp_gd.size(); i++) if (gd_q[i] != exp_gd[i]) bad++;
      check({tag, "_gd_beats"}, bad, 0);
   endtask

   initial begin
      rst          = 1'b1;
      enable       = 1'b1;
      m_ready      = 1'b1;
      fifo_rd_data = '0;
      reset_model();
      clear_sb();
      avail[0] = 5;

      // Reset state while a channel is non-empty and enable is high
      repeat (3) tick();
      check("rst_rd_en",       fifo_rd_en,  4'b0);
      check("rst_m_valid",     m_valid,     1'b0);
      check("rst_m_data",      m_data,      64'h0);
      check("rst_m_ch",        m_ch,        2'd0);
      check("rst_busy",        busy,        1'b0);
      check("rst_grant_done",  grant_done,  1'b0);
      check("rst_grant_beats", grant_beats, 5'd0);
      reset_model();
      enable = 1'b0;
      rst    = 1'b0;
      tick();
      clear_sb();

      // T1: ch1 holds 3 words
      avail[1] = 3;
      enable   = 1'b1;
      en_cyc   = cyc;
      wait_gd("t1_done", 1, 40);
      repeat (3) tick();
      check("t1_beat_count", rx_q.size(), 3);
      for (int i = 0; i < 3; i++) check("t1_beat", rx_q[i], mk_beat(1, i));
      check("t1_gd_count",     gd_q.size(), 1);
      check("t1_grant_beats",  gd_q[0], 3);
      check("t1_first_rd_cyc", rd_cyc[0], en_cyc + 1);
      check("t1_latency",      rx_cyc[0] - rd_cyc[0], 2);
      check("t1_back_to_back", rx_cyc[2] - rx_cyc[0], 2);
      check("t1_gd_cyc",       gd_cyc[0], rd_cyc[2] + 2);
      check("t1_idle",         busy, 1'b0);

      // T2: all channels hold 40 words, m_ready always high
      do_reset();
      build_rr(40);
      for (int k = 0; k < NUM_CH; k++) avail[k] = 40;
      m_ready = 1'b1;
      wait_gd("t2_done", 12, 1500);
      repeat (20) tick();
      compare_stream("t2");
      check("t2_rd_total", rd_total, 160);

      // T3: same load, m_ready high one cycle in three
      do_reset();
      build_rr(40);
      for (int k = 0; k < NUM_CH; k++) avail[k] = 40;
      rdy_mode = 1'b1;
      m_ready  = (cyc % 3 == 0);
      wait_gd("t3_done", 12, 3000);
      repeat (20) tick();
      compare_stream("t3");
      check("t3_rd_total", rd_total, 160);
      check("t3_max_outstanding", max_out, OBUF_DEPTH);
      rdy_mode = 1'b0;
      m_ready  = 1'b1;

      // T4: enable dropped right after the fifth read of a grant
      do_reset();
      enable   = 1'b1;
      avail[0] = 20;
      for (int t = 0; t < 40 && rd_total < 5; t++) tick();
      enable = 1'b0;
      repeat (15) tick();
      push_exp(0, 5);
      compare_stream("t4");
      check("t4_rd_total", rd_total, 5);
      check("t4_idle", busy, 1'b0);

      // T5: ch2 runs dry after 7 reads; ch0 fills mid-burst, ch3 must still come next
      do_reset();
      enable   = 1'b1;
      avail[2] = 7;
      avail[3] = 4;
      for (int t = 0; t < 40 && rd_total < 1; t++) tick();
      avail[0] = 3;
      wait_gd("t5_done", 3, 200);
      repeat (6) tick();
      push_exp(2, 7);
      push_exp(3, 4);
      push_exp(0, 3);
      compare_stream("t5");

      // T6: reset mid-burst with the buffer partly full, then priority restarts at ch0
      do_reset();
      enable   = 1'b1;
      m_ready  = 1'b1;
      avail[1] = 2;
      wait_gd("t6_pre_done", 1, 40);
      repeat (4) tick();
      clear_sb();
      m_ready  = 1'b0;
      avail[3] = 10;
      for (int t = 0; t < 40 && rd_total < 3; t++) tick();
      tick();
      check("t6_buffered_before_rst", m_valid, 1'b1);
      check("t6_busy_before_rst",     busy,    1'b1);
      rst = 1'b1;
      reset_model();
      tick();
      check("t6_rst_m_valid", m_valid, 1'b0);
      check("t6_rst_busy",    busy,    1'b0);
      rst = 1'b0;
      clear_sb();
      avail[1] = 4;
      avail[3] = 4;
      m_ready  = 1'b1;
      wait_gd("t6_done", 2, 100);
      repeat (6) tick();
      push_exp(1, 4);
      push_exp(3, 4);
      compare_stream("t6");

      check("rd_en_onehot", onehot_err, 0);
      check("rd_en_on_empty", rdempty_err, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
